// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int STRB_W     = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection between fetch and data
// Ports: i_req, d_req (requests); rr_last (last granted owner, only when
// MEM_ARBITER_RR_EN is defined); grant (any request); winner (selected owner).
// Macro MEM_ARBITER_RR_EN selects round-robin; otherwise data beats fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
`ifdef MEM_ARBITER_RR_EN
    input  owner_t rr_last,
`endif
    output logic   grant,
    output owner_t winner
);

    always_comb begin
        grant  = i_req | d_req;
        winner = OWN_FETCH;
`ifdef MEM_ARBITER_RR_EN
        // On a tie, whoever was not served last goes next.
        if (i_req && d_req) begin
            winner = (rr_last == OWN_DATA) ? OWN_FETCH : OWN_DATA;
        end else if (d_req) begin
            winner = OWN_DATA;
        end
`else
        if (d_req) begin
            winner = OWN_DATA;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch and data requesters
// Ports: clk/rst (sync active-high); fetch side i_req/i_addr -> i_done/i_rdata;
// data side d_req/d_we/d_wstrb/d_addr/d_wdata -> d_done/d_rdata; memory side
// m_valid/m_we/m_wstrb/m_addr/m_wdata out, m_ready/m_resp/m_rdata in.
// Macro MEM_ARBITER_RR_EN enables round-robin arbitration on simultaneous requests.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_done,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_resp,
    input  logic [DATA_W-1:0]   m_rdata
);

    arb_state_t          state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                m_valid_q, m_valid_d;
    logic                m_we_q, m_we_d;
    logic [DATA_W/8-1:0] m_wstrb_q, m_wstrb_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic                i_done_q, i_done_d;
    logic                d_done_q, d_done_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                grant;
    owner_t              winner;

`ifdef MEM_ARBITER_RR_EN
    owner_t              rr_last_q, rr_last_d;
`endif

    mem_arb_pick u_pick (
        .i_req   (i_req),
        .d_req   (d_req),
`ifdef MEM_ARBITER_RR_EN
        .rr_last (rr_last_q),
`endif
        .grant   (grant),
        .winner  (winner)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        m_valid_d = m_valid_q;
        m_we_d    = m_we_q;
        m_wstrb_d = m_wstrb_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        rr_last_d = rr_last_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d   = winner;
                    m_valid_d = 1'b1;
                    state_d   = ISSUE;
`ifdef MEM_ARBITER_RR_EN
                    rr_last_d = winner;
`endif
                    if (winner == OWN_DATA) begin
                        m_we_d    = d_we;
                        // Loads never carry strobes onto the memory port.
                        m_wstrb_d = d_we ? d_wstrb : '0;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                    end else begin
                        m_we_d    = 1'b0;
                        m_wstrb_d = '0;
                        m_addr_d  = i_addr;
                        m_wdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (m_resp) begin
                    if (owner_q == OWN_DATA) begin
                        d_rdata_d = m_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = m_rdata;
                        i_done_d  = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                // Done pulses here; no grant so the requester can drop req.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_FETCH;
            m_valid_q <= 1'b0;
            m_we_q    <= 1'b0;
            m_wstrb_q <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            rr_last_q <= OWN_FETCH;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            m_valid_q <= m_valid_d;
            m_we_q    <= m_we_d;
            m_wstrb_q <= m_wstrb_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
`ifdef MEM_ARBITER_RR_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_we    = m_we_q;
    assign m_wstrb = m_wstrb_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_req = 1'b0;
    logic [31:0]       i_addr = '0;
    logic              i_done;
    logic [31:0]       i_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [STRB_W-1:0] d_wstrb = '0;
    logic [31:0]       d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic              d_done;
    logic [31:0]       d_rdata;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_we;
    logic [STRB_W-1:0] m_wstrb;
    logic [31:0]       m_addr;
    logic [31:0]       m_wdata;
    logic              m_resp = 1'b0;
    logic [31:0]       m_rdata = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic        own;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_resp(m_resp), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a done pulse, then compare it against the scoreboard head.
    task automatic wait_done(output int waited);
        logic found = 1'b0;
        exp_t e;
        waited = 0;
        for (int k = 0; k < 10; k++) begin
            if (i_done || d_done) begin
                found = 1'b1;
                break;
            end
            tick();
            waited++;
        end
        chk("done_seen", {63'd0, found}, 64'd1);
        if (found) begin
            chk("both_done", {63'd0, i_done & d_done}, 64'd0);
            chk("sb_depth", 64'(sb.size()), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("done_owner", {63'd0, d_done}, {63'd0, e.own});
                chk("done_rdata", {32'd0, d_done ? d_rdata : i_rdata}, {32'd0, e.rdata});
            end
        end
    endtask

    // Wait for the command, accept it at once, respond the next cycle, check done.
    task automatic serve(input logic [31:0] exp_addr, input logic exp_own,
                         input logic [31:0] rdata);
        int n = 0;
        int w;
        m_ready = 1'b1;
        do begin
            tick();
            n++;
        end while (!m_valid && n < 10);
        chk("m_valid_seen", {63'd0, m_valid}, 64'd1);
        chk("m_addr", {32'd0, m_addr}, {32'd0, exp_addr});
        tick();
        chk("m_valid_drop", {63'd0, m_valid}, 64'd0);
        m_resp  = 1'b1;
        m_rdata = rdata;
        sb.push_back('{exp_own, rdata});
        tick();
        m_resp  = 1'b0;
        m_rdata = '0;
        wait_done(w);
        chk("resp_to_done", 64'(w), 64'd0);
    endtask

    initial begin
        int c0;
        int t0;
        int w;
        logic own;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_dones", {62'd0, i_done, d_done}, 64'd0);
        chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
        chk("rst_m_addr", {32'd0, m_addr}, 64'd0);

        // Single fetch with minimum latency
        i_req = 1'b1;
        i_addr = 32'h100;
        c0 = cyc;
        serve(32'h100, 1'b0, 32'h0050_0093);
        chk("fetch_latency", 64'(cyc - c0), 64'd3);
        i_req = 1'b0;
        tick();
        chk("fetch_done_width", {63'd0, i_done}, 64'd0);
        chk("fetch_rdata_hold", {32'd0, i_rdata}, 64'h0050_0093);

        // Store held off by m_ready for five cycles
        d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b0011;
        d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF;
        m_ready = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("bp_valid", {63'd0, m_valid}, 64'd1);
            chk("bp_cmd", {m_addr, m_wdata}, {32'h2004, 32'hDEAD_BEEF});
            chk("bp_we_strb", {59'd0, m_we, m_wstrb}, {59'd0, 1'b1, 4'b0011});
            if (k == 5) m_ready = 1'b1;
            tick();
        end
        chk("bp_accepted", {63'd0, m_valid}, 64'd0);
        m_resp = 1'b1;
        m_rdata = 32'h1111_1111;
        sb.push_back('{1'b1, 32'h1111_1111});
        tick();
        m_resp = 1'b0;
        wait_done(w);
        chk("store_done_lat", 64'(w), 64'd0);
        d_req = 1'b0; d_we = 1'b0; d_wstrb = '0;
        tick();

        // Simultaneous requests: data first, fetch at the following IDLE
        i_req = 1'b1; i_addr = 32'h0300;
        d_req = 1'b1; d_addr = 32'h0404;
        serve(32'h0404, 1'b1, 32'hCAFE_0001);
        t0 = cyc;
        d_req = 1'b0;
        serve(32'h0300, 1'b0, 32'hCAFE_0002);
        chk("contention_gap", 64'(cyc - t0), 64'd4);
        i_req = 1'b0;
        tick();

        // Both requesters continuously asserted for four transactions
        i_req = 1'b1; i_addr = 32'h0500;
        d_req = 1'b1; d_addr = 32'h0600;
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARBITER_RR_EN
            own = (t % 2 == 0);
`else
            own = 1'b1;
`endif
            serve(own ? 32'h0600 : 32'h0500, own, 32'hA000_0000 + 32'(t));
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        tick();

        // Reset while waiting for the response, then a stale response
        i_req = 1'b1; i_addr = 32'h0700;
        m_ready = 1'b1;
        tick();
        chk("rstw_issue", {63'd0, m_valid}, 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_req = 1'b0;
        chk("rstw_valid", {63'd0, m_valid}, 64'd0);
        chk("rstw_rdata", {i_rdata, d_rdata}, 64'd0);
        m_resp = 1'b1;
        m_rdata = 32'hBAD0_0001;
        tick();
        m_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rstw_no_done", {62'd0, i_done, d_done}, 64'd0);
            chk("rstw_idle", {63'd0, m_valid}, 64'd0);
            tick();
        end
        i_req = 1'b1; i_addr = 32'h0800;
        c0 = cyc;
        serve(32'h0800, 1'b0, 32'h1234_5678);
        chk("rstw_fresh_lat", 64'(cyc - c0), 64'd3);
        i_req = 1'b0;
        tick();
        tick();

        // Stray response while idle
        m_resp = 1'b1;
        m_rdata = 32'hBAD0_0002;
        tick();
        m_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stray_no_done", {62'd0, i_done, d_done}, 64'd0);
            chk("stray_valid", {63'd0, m_valid}, 64'd0);
            chk("stray_rdata", {i_rdata, d_rdata}, {32'h1234_5678, 32'd0});
            tick();
        end
        d_req = 1'b1; d_we = 1'b0; d_wstrb = 4'b1111; d_addr = 32'h0900;
        c0 = cyc;
        serve(32'h0900, 1'b1, 32'h5555_AAAA);
        chk("stray_after_lat", 64'(cyc - c0), 64'd3);
        d_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory between the fetch stage (instruction read) and the execute/write stage (data load/store) of the multicycle core.
- Accepts one transaction at a time from either requester, drives the memory-side valid/ready port, waits for the memory response, and returns read data plus a one-cycle done pulse to the owner.
- Sits between core sequencing and the memory model/BRAM wrapper. Fixed priority by default: data over fetch.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch request; held high and stable until i_done
- i_addr  in  ADDR_W  fetch address
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid this cycle
- i_rdata  out  DATA_W  fetched instruction word, held until next i_done
- d_req  in  1  data request; held high and stable until d_done
- d_we  in  1  1 = store, 0 = load
- d_wstrb  in  DATA_W/8  byte strobes for stores
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load data, held until next d_done
- m_valid  out  1  memory command valid
- m_ready  in  1  memory accepts command when m_valid & m_ready
- m_we  out  1  command is a write
- m_wstrb  out  DATA_W/8  write strobes (0 for reads)
- m_addr  out  ADDR_W  command address
- m_wdata  out  DATA_W  write data
- m_resp  in  1  one-cycle response pulse (reads and writes)
- m_rdata  in  DATA_W  read data, valid with m_resp

Behaviour:
- All outputs are registered. Reset (rst sampled high at a clk edge) forces state IDLE, all m_* outputs 0, i_done and d_done 0, i_rdata and d_rdata 0, owner = fetch, rr_last = fetch.
- States:
  - IDLE: at the edge, if any req is high, pick the winner, latch its addr/we/wstrb/wdata into m_* (fetch: m_we=0, m_wstrb=0), set m_valid=1, go to ISSUE.
  - ISSUE: m_valid=1; on m_valid & m_ready, clear m_valid and go to WAIT. If m_ready=0, hold the command stable indefinitely.
  - WAIT: on m_resp, register m_rdata into the owner's rdata, pulse the owner's done, go to RESP.
  - RESP: done is high for exactly this cycle. No grant is made in RESP. Next state is IDLE.
- m_resp in the same cycle as acceptance (ISSUE) is illegal; the memory responds no earlier than the cycle after acceptance. m_resp outside WAIT is ignored.
- Minimum latency, with req first seen at edge 0 and m_ready=1 immediately: m_valid in cycle 1, m_resp in cycle 2, done in cycle 3. Back-to-back grants are therefore 4 cycles apart.
- The requester deasserts req at the edge ending its done cycle (or issues a new request). The arbiter samples req only in IDLE.
- Simultaneous i_req and d_req in IDLE: data wins; fetch stays pending and is granted on the next IDLE.
- Request inputs are sampled only at the grant edge. Changes made afterwards are a requester protocol violation with undefined results.
- Reset mid-operation: aborts immediately to IDLE with outputs cleared. A stale m_resp arriving later is ignored because it lands in IDLE.
- i_done and d_done are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined: round-robin between the two requesters. On simultaneous requests in IDLE, the requester not equal to rr_last wins. rr_last updates at every grant.
- Undefined: fixed priority, data over fetch. rr_last logic is removed.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP; 2 bits)
  - owner_t enum (OWN_FETCH, OWN_DATA)
  - localparam STRB_W = DATA_W/8
- One natural sub-module: mem_arb_pick, a combinational winner selection from i_req, d_req and rr_last. It is ifdef-controlled for the round-robin variant.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, m_ready=1, m_resp in cycle 2 with m_rdata=0x00500093 -> m_valid in cycle 1 only, m_addr=0x100, m_we=0, i_done pulse in cycle 3, i_rdata=0x00500093.
- Store with backpressure: d_req=1, d_we=1, d_wstrb=4'b0011, d_addr=0x2004, d_wdata=0xDEADBEEF, m_ready held 0 for 5 cycles -> m_* stable for all 6 ISSUE cycles; d_done 1 cycle after m_resp.
- Contention: i_req and d_req asserted together -> data granted first. Fetch is granted at the IDLE after d_done; i_done arrives at least 4 cycles after d_done.
- Round-robin variant (MEM_ARBITER_RR_EN): both requests continuously re-asserted for 4 transactions -> grants alternate D,F,D,F.
- Reset during WAIT, then m_resp pulse after reset -> no done pulse, m_valid=0, arbiter returns to IDLE and accepts a fresh i_req normally.
- Stray m_resp while IDLE, with no request pending -> no done pulse and no state change.
